// File: rtl/cic_comb_decimator_comb_stage.sv
// One comb section of the CIC decimator: y <= x - x_prev on each valid sample,
// modulo 2^W, with a one-cycle valid flag following the input strobe.
module comb_stage #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] x,
    input  logic         v,
    output logic [W-1:0] y,
    output logic         v_out
);

    logic [W-1:0] d_q, d_d;
    logic [W-1:0] y_q, y_d;
    logic         v_q, v_d;

    // Data and delay only move on a valid sample; the flag always follows v.
    always_comb begin
        d_d = d_q;
        y_d = y_q;
        v_d = v;
        if (v) begin
            y_d = x - d_q;
            d_d = x;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_q <= '0;
            y_q <= '0;
            v_q <= 1'b0;
        end else begin
            d_q <= d_d;
            y_q <= y_d;
            v_q <= v_d;
        end
    end

    assign y     = y_q;
    assign v_out = v_q;

endmodule

// File: rtl/cic_comb_decimator.sv
// CIC decimator back end: keeps every R-th valid integrator sample and feeds it
// through N pipelined comb stages; one out_valid strobe per R valid inputs.
module cic_comb_decimator #(
    parameter int unsigned W = 32,
    parameter int unsigned R = 4,
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in,
    input  logic         in_valid,
    output logic [W-1:0] out,
    output logic         out_valid
);

    localparam int unsigned CW = $clog2(R);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          taken_c;

    // Decimation counter: wraps on the R-th valid sample, which is the one kept.
    always_comb begin
        cnt_d   = cnt_q;
        taken_c = 1'b0;
        if (in_valid) begin
            if (cnt_q == CW'(R - 1)) begin
                cnt_d   = '0;
                taken_c = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    logic [W-1:0] x_s [N+1];
    logic         v_s [N+1];

    assign x_s[0] = in;
    assign v_s[0] = taken_c;

    for (genvar i = 0; i < N; i++) begin : g_comb
        comb_stage #(.W(W)) u_stage (
            .clk   (clk),
            .reset (reset),
            .x     (x_s[i]),
            .v     (v_s[i]),
            .y     (x_s[i+1]),
            .v_out (v_s[i+1])
        );
    end

    assign out       = x_s[N];
    assign out_valid = v_s[N];

endmodule
